run_length_detector: RTL

Parametrised serial run-length detector: samples one bit per enabled clock and flags every run of `RUN_LEN` identical bits. Mode inputs select which bit value is watched and whether detections overlap. A saturating detection counter supports statistics readout. It sits between a synchronised serial input (switch/pin sampler) and the LED/status display path, and supersedes the fixed four-in-a-row detector.

---
 rtl/run_length_detector_pkg.sv | 32 +++
 rtl/run_length_detector_if.sv | 34 +++
 rtl/run_length_detector_sat_counter.sv | 33 +++
 rtl/run_length_detector.sv | 79 +++++++
 4 files changed

// File: rtl/run_length_detector_pkg.sv
// Shared types for the run-length detector: one-hot FSM state and mode codes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: run_state_t (IDLE/RUN0/RUN1 one-hot), MODE_* constants, mode_permits().
package run_det_pkg;

  // One-hot so the state register can be driven straight onto state_oh {RUN1,RUN0,IDLE}.
  typedef enum logic [2:0] {
    IDLE = 3'b001,
    RUN0 = 3'b010,
    RUN1 = 3'b100
  } run_state_t;

  localparam logic [1:0] MODE_BOTH = 2'b00;
  localparam logic [1:0] MODE_ZERO = 2'b01;
  localparam logic [1:0] MODE_ONE  = 2'b10;
  localparam logic [1:0] MODE_OFF  = 2'b11;

  // True when a completed run of value b may raise a detection under this mode.
  function automatic logic mode_permits(input logic [1:0] mode, input logic b);
    logic ok;
    ok = 1'b0;
    case (mode)
      MODE_BOTH: ok = 1'b1;
      MODE_ZERO: ok = ~b;
      MODE_ONE:  ok = b;
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/run_length_detector_if.sv
// Bundle of the detector's sample inputs, mode controls and status outputs.
// Latency: n/a (wiring only).
// Backpressure: none; en qualifies each sample, there is no ready.
// Modports: master drives en/w/mode/overlap/clr_cnt; slave (detector) drives
//   z/z_val/run_cnt/state_oh/det_cnt/det_ovf.
interface run_length_detector_if #(
  parameter int RUN_LEN = 4,
  parameter int CNT_W   = 8
);
  localparam int RC_W = $clog2(RUN_LEN + 1);

  logic             en;
  logic             w;
  logic [1:0]       mode;
  logic             overlap;
  logic             clr_cnt;
  logic             z;
  logic             z_val;
  logic [RC_W-1:0]  run_cnt;
  logic [2:0]       state_oh;
  logic [CNT_W-1:0] det_cnt;
  logic             det_ovf;

  modport master (
    output en, w, mode, overlap, clr_cnt,
    input  z, z_val, run_cnt, state_oh, det_cnt, det_ovf
  );

  modport slave (
    input  en, w, mode, overlap, clr_cnt,
    output z, z_val, run_cnt, state_oh, det_cnt, det_ovf
  );

endinterface

// File: rtl/run_length_detector_sat_counter.sv
// Saturating hit counter with sticky overflow flag and synchronous clear.
// Latency: 1 cycle from inc/clr to cnt/ovf.
// Backpressure: none; increments past the maximum are absorbed into ovf.
// Ports: clk, rstn (sync active-low), inc, clr, cnt[width], ovf.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt,
  output logic             ovf
);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      // A hit landing on the clear cycle is kept rather than lost.
      cnt <= WIDTH'(inc);
      ovf <= 1'b0;
    end else if (inc) begin
      if (&cnt) begin
        ovf <= 1'b1;
      end else begin
        cnt <= cnt + WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/run_length_detector.sv
// Serial run-length detector: flags every run of RUN_LEN identical accepted bits.
// Latency: z/z_val/run_cnt/state_oh update 1 cycle after the accepting edge; all outputs registered.
// Backpressure: none; en low freezes state and run count and forces z low.
// Ports: Clock, Resetn (sync active-low), bus (slave modport: en, w, mode, overlap,
//   clr_cnt in; z, z_val, run_cnt, state_oh, det_cnt, det_ovf out).
module run_length_detector #(
  parameter int RUN_LEN = 4,
  parameter int CNT_W   = 8
) (
  input logic                 Clock,
  input logic                 Resetn,
  run_length_detector_if.slave bus
);
  import run_det_pkg::*;

  localparam int RC_W = $clog2(RUN_LEN + 1);
  // One extra bit so run_cnt+1 never wraps when run_cnt already sits at RUN_LEN.
  localparam logic [RC_W:0] RUN_LEN_N = (RC_W + 1)'(RUN_LEN);

  run_state_t      state;
  logic [RC_W-1:0] run_cnt_q;
  logic            z_q;
  logic            z_val_q;

  logic            run_bit;
  logic            same;
  logic [RC_W:0]   n;
  logic            reached;
  logic            hit;

  always_comb begin
    run_bit = (state == RUN1);
    same    = (state != IDLE) && (bus.w == run_bit);
    n       = {1'b0, run_cnt_q} + (RC_W + 1)'(1);
    reached = same && (n >= RUN_LEN_N);
    hit     = bus.en && reached && mode_permits(bus.mode, run_bit);
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state     <= IDLE;
      run_cnt_q <= '0;
      z_q       <= 1'b0;
      z_val_q   <= 1'b0;
    end else begin
      z_q <= hit;
      if (hit) begin
        z_val_q <= run_bit;
      end
      if (bus.en) begin
        if (!same) begin
          state     <= bus.w ? RUN1 : RUN0;
          run_cnt_q <= RC_W'(1);
        end else if (bus.overlap) begin
          run_cnt_q <= reached ? RC_W'(RUN_LEN) : n[RC_W-1:0];
        end else begin
          // Non-overlap restarts at 0 after reaching the threshold; this also
          // covers a switch from overlap mode with run_cnt parked at RUN_LEN.
          run_cnt_q <= reached ? '0 : n[RC_W-1:0];
        end
      end
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_det_cnt (
    .clk  (Clock),
    .rstn (Resetn),
    .inc  (hit),
    .clr  (bus.clr_cnt),
    .cnt  (bus.det_cnt),
    .ovf  (bus.det_ovf)
  );

  assign bus.z        = z_q;
  assign bus.z_val    = z_val_q;
  assign bus.run_cnt  = run_cnt_q;
  assign bus.state_oh = state;

endmodule
